// File: rtl/sram_share_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the CPU inst (I) and data (D) ports.
// Optional performance counters are enabled by defining SRAM_ARB_PERF_EN.
module sram_share_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned DW        = 32,
  localparam int unsigned WEW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_req,
  input  logic [WEW-1:0] i_we,
  input  logic [31:0]    i_addr,
  input  logic [DW-1:0]  i_wdata,
  output logic           i_gnt,
  output logic           i_rvalid,
  output logic [DW-1:0]  i_rdata,
  input  logic           d_req,
  input  logic [WEW-1:0] d_we,
  input  logic [31:0]    d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  output logic [DW-1:0]  d_rdata,
  output logic           ram_en,
  output logic [WEW-1:0] ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]    perf_conflict,
  output logic [31:0]    perf_i_stall,
  output logic [31:0]    perf_d_stall
`endif
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } rd_tag_e;

  rd_tag_e         rd_tag_q, rd_tag_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            grant_i, grant_d;
  logic [31:0]     sel_addr;
  logic [WEW-1:0]  sel_we;
  logic            unused_addr_bits_c;

  // Byte-offset and upper address bits never reach the SRAM (requires AW <= 29).
  assign unused_addr_bits_c = ^{i_addr[1:0], d_addr[1:0], i_addr[31:AW+2], d_addr[31:AW+2]};

  // Grant: D wins conflicts unless I has been denied STARVE_MAX cycles in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
        if (starve_cnt_q == CW'(STARVE_MAX)) grant_i = 1'b1;
        else                                 grant_d = 1'b1;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  // SRAM drive muxed from the winner.
  always_comb begin
    sel_addr  = grant_i ? i_addr  : d_addr;
    sel_we    = grant_i ? i_we    : d_we;
    ram_en    = grant_i | grant_d;
    ram_we    = ram_en ? sel_we : '0;
    ram_addr  = sel_addr[AW+1:2];
    ram_wdata = grant_i ? i_wdata : d_wdata;
  end

  // Next-state for the starvation counter and in-flight read tag.
  always_comb begin
    starve_cnt_d = '0;
    rd_tag_d     = TAG_NONE;
    if (i_req && !grant_i) begin
      starve_cnt_d = (starve_cnt_q >= CW'(STARVE_MAX)) ? starve_cnt_q
                                                       : starve_cnt_q + CW'(1);
    end
    if (grant_i && (i_we == '0))      rd_tag_d = TAG_I;
    else if (grant_d && (d_we == '0)) rd_tag_d = TAG_D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rd_tag_q     <= TAG_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // Read return: both rdata buses mirror the SRAM; rvalid is dropped while reset is asserted.
  assign i_rvalid = (rd_tag_q == TAG_I) && !reset;
  assign d_rvalid = (rd_tag_q == TAG_D) && !reset;
  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

`ifdef SRAM_ARB_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_i_stall  <= '0;
      perf_d_stall  <= '0;
    end else begin
      if (i_req && d_req)    perf_conflict <= perf_conflict + 32'(1);
      if (i_req && !grant_i) perf_i_stall  <= perf_i_stall  + 32'(1);
      if (d_req && !grant_d) perf_d_stall  <= perf_d_stall  + 32'(1);
    end
  end
`endif

endmodule
